wb_host_bridge: RTL and testbench
=================================

# wb_host_bridge

Wishbone classic initiator that pairs with the user-project Wishbone responder port set (`wbs_*`). It accepts single-word commands on a valid/ready command channel, runs exactly one Wishbone classic cycle per command, and returns read data or an error on a valid/ready response channel. A per-transfer timeout converts a missing `ack` into an error response. It is used as the bus driver in test harnesses and by on-chip agents that need to reach Wishbone-mapped user registers.

## Interface

**Parameters**

- `TIMEOUT`, default 255: number of strobe cycles without `ack` before the transfer is aborted; legal range 1..65535.

**Ports**

- `wb_clk_i` input 1: single clock; all logic is rising-edge.
- `wb_rst_n_i` input 1: reset, asynchronous assert, active-low.
- `cmd_valid_i` input 1: command present.
- `cmd_ready_o` output 1: bridge accepts a command.
- `cmd_we_i` input 1: 1 = write, 0 = read.
- `cmd_sel_i` input 4: byte selects.
- `cmd_adr_i` input 32: byte address.
- `cmd_dat_i` input 32: write data.
- `wbm_cyc_o` output 1: Wishbone cycle.
- `wbm_stb_o` output 1: Wishbone strobe.
- `wbm_we_o` output 1: Wishbone write enable.
- `wbm_sel_o` output 4: Wishbone byte selects.
- `wbm_adr_o` output 32: Wishbone address.
- `wbm_dat_o` output 32: Wishbone write data.
- `wbm_ack_i` input 1: Wishbone acknowledge.
- `wbm_dat_i` input 32: Wishbone read data.
- `rsp_valid_o` output 1: response present.
- `rsp_ready_i` input 1: consumer accepts the response.
- `rsp_dat_o` output 32: read data. Zero for writes and for errors.
- `rsp_err_o` output 1: 1 = timeout abort.

## Operation

**State machine**

- States are IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i & cmd_ready_o`, register `we/sel/adr/dat` into the `wbm_*` output registers, clear the timeout counter, and go to BUS.
- BUS:
  - `wbm_cyc_o` = `wbm_stb_o` = 1.
  - `wbm_we_o/sel_o/adr_o/dat_o` stay stable for the whole cycle.
  - On `wbm_ack_i` = 1:
    - capture `rsp_dat_o` = (`we` ? 0 : `wbm_dat_i`) and set `rsp_err_o` = 0;
    - deassert `cyc/stb` and go to RESP.
  - Otherwise, if the counter equals `TIMEOUT-1`:
    - set `rsp_err_o` = 1 and `rsp_dat_o` = 0;
    - deassert `cyc/stb` and go to RESP.
  - Otherwise the counter increments.
- RESP:
  - `rsp_valid_o` = 1, with `rsp_dat_o`/`rsp_err_o` held stable.
  - On `rsp_ready_i` = 1, go to IDLE.
  - `wbm_ack_i` is ignored in RESP and IDLE (late or stray acks).

**Other rules**

- `cmd_ready_o` is a decode of state IDLE only. It does not depend combinationally on `cmd_valid_i`.
- Exactly one outstanding transfer at a time. No pipelining, no bursts, `cyc` == `stb` always.
- Counter width is `$clog2(TIMEOUT+1)`. It never wraps, because it is cleared at each command accept.

**Reset values** (all outputs 0 except `cmd_ready_o`)

- `cmd_ready_o` = 1.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0.
- `wbm_sel_o`, `wbm_adr_o`, `wbm_dat_o` = 0.
- `rsp_valid_o` = 0, `rsp_dat_o` = 0, `rsp_err_o` = 0.

## Timing

- Command accepted at edge 0; `cyc/stb` are high from cycle 1.
- `ack` sampled high at the end of cycle k:
  - `cyc/stb` are low in cycle k+1;
  - `rsp_valid_o` is high in cycle k+1.
- Zero-wait responder (ack in cycle 1): `rsp_valid_o` is high in cycle 2.
- Response handshake in cycle r: `cmd_ready_o` is high in cycle r+1. Minimum command-to-command spacing is 3 cycles with an immediate ack and `rsp_ready_i` held high.
- Timeout: with `cyc/stb` first high in cycle 1 and no ack in cycles 1..TIMEOUT, `cyc/stb` are low and `rsp_valid_o`/`rsp_err_o` are high in cycle TIMEOUT+1.
- Ack in the same cycle as the timeout threshold: ack wins, and a normal response is returned with `err` = 0.
- Response backpressure: `rsp_valid_o` and its data hold indefinitely while `rsp_ready_i` = 0. `cmd_ready_o` stays 0 during this time.
- Reset asserted mid-transfer: `cyc/stb` and `rsp_valid_o` drop asynchronously, and the pending transfer is discarded with no response. After reset deasserts, the first edge sees IDLE.

## Test plan

- **Read, 2-wait responder.** Command read, `adr=0x3000_0004`, `sel=0xF`. The responder acks in the 3rd strobe cycle with `0xDEAD_BEEF`.
  - Required: `cyc/stb` high for exactly 3 cycles.
  - Required: `rsp_valid_o` next cycle with `rsp_dat_o=0xDEAD_BEEF`, `rsp_err_o=0`.
- **Write, zero-wait responder.** Command write, `adr=0x3000_0000`, `dat=0x1234_5678`, `sel=0x3`.
  - Required: one strobe cycle with `wbm_we_o=1`, `sel=0x3`, `dat=0x1234_5678`.
  - Required: then `rsp_valid_o` with `rsp_dat_o=0`, `rsp_err_o=0`.
  - Required: `cmd_ready_o` back high 3 cycles after accept.
- **Timeout, no ack.** `TIMEOUT=4`, responder never acks.
  - Required: `stb` high exactly 4 cycles.
  - Required: then `rsp_err_o=1`, `rsp_dat_o=0`.
  - Required: a stray ack 2 cycles later is ignored.
- **Ack on the threshold cycle.** `TIMEOUT=4`, ack arrives in the 4th strobe cycle with `0xA5A5_A5A5`.
  - Required: `rsp_err_o=0`, `rsp_dat_o=0xA5A5_A5A5`.
- **Response backpressure.** `rsp_ready_i` held 0 for 10 cycles with `cmd_valid_i` held 1.
  - Required: `rsp_valid_o`/data stable throughout, `cmd_ready_o=0`, no new `cyc`.
  - Required: the next command is accepted exactly 1 cycle after the `rsp_ready_i` handshake.
- **Reset mid-transfer.** Assert `wb_rst_n_i=0` asynchronously while `stb` is high.
  - Required: `cyc/stb` fall before the next edge; all outputs at reset values.
  - Required: no response is emitted after release.
  - Required: a subsequent read completes normally.

Source files
------------

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: Wishbone classic initiator with one outstanding transfer.
// Commands arrive on a valid/ready channel, each one runs a single classic
// cycle, and the result (read data or a timeout error) is returned on a
// valid/ready response channel.
`timescale 1ns/1ps

module wb_host_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o
);

    // Counter only has to reach TIMEOUT-1; it is cleared on every accept.
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             we_q,      we_d;
    logic [3:0]       sel_q,     sel_d;
    logic [31:0]      adr_q,     adr_d;
    logic [31:0]      dat_q,     dat_d;
    logic [31:0]      rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    // Next-state logic: accept in IDLE, wait for ack or timeout in BUS,
    // hold the result in RESP until the consumer takes it.
    always_comb begin
        // NOTE: every _d defaults to its _q before the case so that no path
        // leaves a signal unassigned; otherwise synthesis infers latches.
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack has priority over the timeout threshold.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            // NOTE: the datapath registers are reset too (not just the state)
            // because they drive module outputs that must read zero in reset.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            rsp_dat_q <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Handshake and bus controls are pure decodes of the registered state,
    // so they drop immediately when reset is asserted.
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign wbm_cyc_o   = (state_q == ST_BUS);
    assign wbm_stb_o   = (state_q == ST_BUS);
    assign rsp_valid_o = (state_q == ST_RESP);

    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Testbench for wb_host_bridge: directed scenarios plus randomized traffic.
// Stimulus pushes expected bus transfers and responses into queues; a bus
// agent (responder + bus checker) and a response monitor consume them.
`timescale 1ns/1ps

module tb_wb_host_bridge;

    localparam int unsigned TIMEOUT = 4;
    localparam int          NEVER   = 1000;  // wait count that never acks

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          wait_n;  // ack arrives in strobe cycle wait_n+1
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        wb_rst_n_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [3:0]  cmd_sel_i = 4'd0;
    logic [31:0] cmd_adr_i = 32'd0;
    logic [31:0] cmd_dat_i = 32'd0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    xfer_t bus_q[$];
    rsp_t  rsp_q[$];

    int   checks = 0;
    int   errors = 0;
    logic stray_ack  = 1'b0;
    logic ready_rand = 1'b0;
    logic ready_force = 1'b1;

    wb_host_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (wb_rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred where none was required", name);
    endtask

    // Reference model: a transfer acks if its ack cycle falls within the
    // first TIMEOUT strobe cycles, otherwise it times out after TIMEOUT.
    function automatic int exp_stb_len(input int wait_n);
        return (wait_n < int'(TIMEOUT)) ? wait_n + 1 : int'(TIMEOUT);
    endfunction

    function automatic rsp_t exp_rsp(input xfer_t x);
        rsp_t r;
        if (x.wait_n < int'(TIMEOUT)) begin
            r.err = 1'b0;
            r.dat = x.we ? 32'd0 : x.rdata;
        end else begin
            r.err = 1'b1;
            r.dat = 32'd0;
        end
        return r;
    endfunction

    function automatic xfer_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                 input logic [31:0] dat, input int wait_n, input logic [31:0] rdata);
        xfer_t x;
        x.we = we; x.sel = sel; x.adr = adr; x.dat = dat; x.wait_n = wait_n; x.rdata = rdata;
        return x;
    endfunction

    task automatic check_reset_values(input string name);
        check(name, {cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
                     wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_err_o}, {1'b1, 105'd0});
    endtask

    task automatic set_cmd(input xfer_t x);
        cmd_valid_i = 1'b1;
        cmd_we_i    = x.we;
        cmd_sel_i   = x.sel;
        cmd_adr_i   = x.adr;
        cmd_dat_i   = x.dat;
    endtask

    task automatic drive_cmd(input xfer_t x);
        @(posedge clk); #1;
        set_cmd(x);
    endtask

    task automatic push_expect(input xfer_t x);
        bus_q.push_back(x);
        rsp_q.push_back(exp_rsp(x));
    endtask

    // Called at posedge+1 with the command driven; returns at posedge+1 of
    // the first BUS cycle.
    task automatic wait_accept(input xfer_t x);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready_o) fail("accept_timeout");
        @(posedge clk); #1;
        push_expect(x);
        cmd_valid_i = 1'b0;
    endtask

    task automatic send(input xfer_t x);
        drive_cmd(x);
        wait_accept(x);
    endtask

    // Counts cycles after the accept until rsp_valid_o is seen.
    task automatic wait_rsp(input string name, input int exp_cyc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rsp_valid_o && c < 200);
        check(name, c, exp_cyc);
    endtask

    // Response-ready driver: forced value or random per cycle.
    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk); #2;
            rsp_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Bus agent: acts as the responder and checks every strobe cycle and
    // the strobe length against the expected transfer.
    initial begin
        xfer_t cur;
        bit    active;
        int    cnt;
        active = 1'b0;
        cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (!wb_rst_n_i) begin
                active = 1'b0;
                cnt = 0;
                wbm_ack_i = 1'b0;
            end else if (wbm_cyc_o || wbm_stb_o) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        fail("unexpected_cycle");
                    end else begin
                        cur = bus_q.pop_front();
                        active = 1'b1;
                        cnt = 0;
                    end
                end
                if (active) begin
                    cnt++;
                    check("bus_attr", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
                          {2'b11, cur.we, cur.sel, cur.adr, cur.dat});
                    wbm_ack_i = (cnt == cur.wait_n + 1);
                    wbm_dat_i = wbm_ack_i ? cur.rdata : $urandom;
                end else begin
                    wbm_ack_i = 1'b0;
                end
            end else begin
                if (active) begin
                    check("stb_len", cnt, exp_stb_len(cur.wait_n));
                    active = 1'b0;
                end
                wbm_ack_i = stray_ack;
                wbm_dat_i = $urandom;
            end
        end
    end

    // Response monitor: compares each accepted response with the model.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_rst_n_i && rsp_valid_o && rsp_ready_i) begin
                if (rsp_q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp", {rsp_err_o, rsp_dat_o}, {e.err, e.dat});
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        xfer_t x, y;
        rsp_t  ex;

        // Reset state.
        #1 wb_rst_n_i = 1'b0;
        #2 check_reset_values("reset_in_reset");
        repeat (3) @(posedge clk);
        @(negedge clk); #2 wb_rst_n_i = 1'b1;
        @(negedge clk);
        check_reset_values("reset_after_release");

        // Read with a 2-wait responder.
        x = mk(1'b0, 4'hF, 32'h3000_0004, $urandom, 2, 32'hDEAD_BEEF);
        send(x);
        wait_rsp("read_2wait_rsp_cycle", 4);

        // Write with a zero-wait responder; ready returns 3 cycles after accept.
        x = mk(1'b1, 4'h3, 32'h3000_0000, 32'h1234_5678, 0, $urandom);
        send(x);
        wait_rsp("write_0wait_rsp_cycle", 2);
        @(negedge clk);
        check("write_ready_after_3", cmd_ready_o, 1'b1);

        // Timeout with no ack, then a stray ack two cycles after strobe drops.
        x = mk(1'b0, 4'hF, 32'h3000_0008, $urandom, NEVER, 32'd0);
        send(x);
        wait_rsp("timeout_rsp_cycle", int'(TIMEOUT) + 1);
        check("timeout_err_flag", {rsp_err_o, rsp_dat_o}, {1'b1, 32'd0});
        @(posedge clk); #1;
        @(posedge clk); #1; stray_ack = 1'b1;
        @(posedge clk); #1; stray_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_ack_ignored", {wbm_cyc_o, rsp_valid_o, cmd_ready_o}, 3'b001);
        end

        // Ack on the timeout threshold cycle wins.
        x = mk(1'b0, 4'hF, 32'h3000_000C, $urandom, 3, 32'hA5A5_A5A5);
        send(x);
        wait_rsp("threshold_rsp_cycle", int'(TIMEOUT) + 1);

        // Response backpressure with the next command already waiting.
        ready_force = 1'b0;
        x = mk(1'b0, 4'hC, 32'h3000_0010, $urandom, 1, $urandom);
        send(x);
        y = mk(1'b1, 4'h9, 32'h3000_0014, $urandom, 0, $urandom);
        set_cmd(y);
        wait_rsp("bp_rsp_cycle", 3);
        ex = exp_rsp(x);
        repeat (10) begin
            check("bp_hold", {rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o, wbm_cyc_o},
                  {1'b1, ex.err, ex.dat, 1'b0, 1'b0});
            @(negedge clk);
        end
        @(posedge clk); #1; ready_force = 1'b1;
        @(negedge clk);
        check("bp_ready_in_handshake_cycle", cmd_ready_o, 1'b0);
        @(negedge clk);
        check("bp_ready_after_handshake", {cmd_ready_o, wbm_cyc_o}, 2'b10);
        @(posedge clk); #1;
        push_expect(y);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("bp_next_accepted", wbm_cyc_o, 1'b1);
        @(negedge clk);
        check("bp_next_rsp", rsp_valid_o, 1'b1);

        // Reset asserted mid-transfer.
        x = mk(1'b0, 4'hF, 32'h3000_0020, $urandom, NEVER, 32'd0);
        send(x);
        @(negedge clk);
        @(negedge clk); #2;
        check("rst_stb_before", wbm_stb_o, 1'b1);
        wb_rst_n_i = 1'b0;
        #1;
        check_reset_values("rst_async_values");
        rsp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #2 wb_rst_n_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_no_rsp", {rsp_valid_o, wbm_cyc_o}, 2'b00);
        end
        x = mk(1'b0, 4'h5, 32'h3000_0024, $urandom, 1, $urandom);
        send(x);
        wait_rsp("rst_next_read_rsp_cycle", 3);

        // Randomized traffic with random response backpressure.
        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 5)), $urandom);
            send(x);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        // Drain.
        ready_rand = 1'b0;
        ready_force = 1'b1;
        for (int n = 0; n < 200 && (rsp_q.size() != 0 || bus_q.size() != 0); n++) begin
            @(negedge clk);
        end
        check("queues_drained", rsp_q.size() + bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
